// File: rtl/peripheral_noc_master_if.sv
// Host command/response and peripheral bus signals of the NoC master.
// The master modport is the DUT view; slave is the host-plus-peripheral view.
interface peripheral_noc_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_wr;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, cmd_we, rsp_ready, per_dout,
        output cmd_ready, rsp_valid, rsp_data, rsp_wr,
               per_addr, per_din, per_en, per_we
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, cmd_we, rsp_ready, per_dout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_wr,
               per_addr, per_din, per_en, per_we
    );
endinterface

// File: rtl/peripheral_noc_master.sv
// Queues host commands in a FIFO and issues them one at a time on the peripheral bus.
// Optional transfer counter port enabled by defining PERIPHERAL_NOC_MASTER_STATS_EN.
module peripheral_noc_master #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    peripheral_noc_master_if.master bus
`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
    ,
    output logic [15:0]             stat_xfer_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t        state_r;
    logic [31:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [13:0]   per_addr_r;
    logic [15:0]   per_din_r;
    logic          per_en_r;
    logic [1:0]    per_we_r;
    logic          rsp_valid_r;
    logic [15:0]   rsp_data_r;
    logic          rsp_wr_r;

    logic          cmd_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          not_empty_s;
    logic [31:0]   head_s;

    // Entry layout is {addr[13:0], data[15:0], we[1:0]}.
    assign cmd_ready_s = (count_r != FULL_C);
    assign not_empty_s = (count_r != {CW{1'b0}});
    assign push_s      = bus.cmd_valid && cmd_ready_s;
    assign pop_s       = (state_r == ACCESS);
    assign head_s      = mem_r[rd_ptr_r];

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.per_addr  = per_addr_r;
    assign bus.per_din   = per_din_r;
    assign bus.per_en    = per_en_r;
    assign bus.per_we    = per_we_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_wr    = rsp_wr_r;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge mclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.cmd_addr, bus.cmd_data, bus.cmd_we};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Access sequencer; the bus is loaded from the FIFO head on entry to ACCESS
    // so every peripheral-side output comes straight from a register.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_r     <= IDLE;
            per_addr_r  <= 14'h0000;
            per_din_r   <= 16'h0000;
            per_en_r    <= 1'b0;
            per_we_r    <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 16'h0000;
            rsp_wr_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (not_empty_s) begin
                        state_r    <= ACCESS;
                        per_en_r   <= 1'b1;
                        per_addr_r <= head_s[31:18];
                        per_din_r  <= head_s[17:2];
                        per_we_r   <= head_s[1:0];
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r     <= RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= (per_we_r == 2'b00) ? bus.per_dout : 16'h0000;
                    rsp_wr_r    <= (per_we_r != 2'b00);
                    per_en_r    <= 1'b0;
                    per_addr_r  <= 14'h0000;
                    per_din_r   <= 16'h0000;
                    per_we_r    <= 2'b00;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (not_empty_s) begin
                            state_r    <= ACCESS;
                            per_en_r   <= 1'b1;
                            per_addr_r <= head_s[31:18];
                            per_din_r  <= head_s[17:2];
                            per_we_r   <= head_s[1:0];
                        end else begin
                            state_r    <= IDLE;
                        end
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    per_en_r    <= 1'b0;
                    per_addr_r  <= 14'h0000;
                    per_din_r   <= 16'h0000;
                    per_we_r    <= 2'b00;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
    logic [15:0] stat_xfer_cnt_r;

    // Counts ACCESS cycles, wrapping naturally at 16 bits.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            stat_xfer_cnt_r <= 16'h0000;
        end else if (state_r == ACCESS) begin
            stat_xfer_cnt_r <= stat_xfer_cnt_r + 16'h0001;
        end else begin
            stat_xfer_cnt_r <= stat_xfer_cnt_r;
        end
    end

    assign stat_xfer_cnt = stat_xfer_cnt_r;
`endif

endmodule

// File: tb/tb_peripheral_noc_master.sv
// Directed bench for peripheral_noc_master: read, write, backpressure, full FIFO, reset abort.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_peripheral_noc_master;
    logic mclk;
    logic puc_rst_n;
    int   n_total;
    int   n_bad;
    int   cyc;
    int   push_cnt;
    logic [13:0] en_addr_q [$];
    logic [15:0] en_din_q  [$];
    int          en_cyc_q  [$];

    peripheral_noc_master_if bus_if ();

`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
    logic [15:0] stat_xfer_cnt;
`endif

    peripheral_noc_master #(.FIFO_DEPTH(4)) dut (
        .mclk          (mclk),
        .puc_rst_n     (puc_rst_n),
        .bus           (bus_if)
`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
        ,
        .stat_xfer_cnt (stat_xfer_cnt)
`endif
    );

    always #5 mclk = ~mclk;

    // Records every peripheral access (pre-edge values) and accepted push.
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (bus_if.per_en) begin
            en_addr_q.push_back(bus_if.per_addr);
            en_din_q.push_back(bus_if.per_din);
            en_cyc_q.push_back(cyc);
        end
        if (bus_if.cmd_valid && bus_if.cmd_ready) begin
            push_cnt <= push_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total = n_total + 1;
        if (obs !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic push(input logic [13:0] a, input logic [15:0] d, input logic [1:0] w);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_addr  = a;
        bus_if.cmd_data  = d;
        bus_if.cmd_we    = w;
        check("push_ready", 32'(bus_if.cmd_ready), 32'd1);
        @(negedge mclk);
        bus_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int n_before;
        mclk = 1'b0;
        puc_rst_n = 1'b0;
        n_total = 0;
        n_bad = 0;
        cyc = 0;
        push_cnt = 0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = 14'h0000;
        bus_if.cmd_data  = 16'h0000;
        bus_if.cmd_we    = 2'b00;
        bus_if.rsp_ready = 1'b0;
        bus_if.per_dout  = 16'h0000;

        // Reset state
        step(2);
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus_if.rsp_data),  32'd0);
        check("rst_rsp_wr",    32'(bus_if.rsp_wr),    32'd0);
        check("rst_per_en",    32'(bus_if.per_en),    32'd0);
        check("rst_per_we",    32'(bus_if.per_we),    32'd0);
        check("rst_per_addr",  32'(bus_if.per_addr),  32'd0);
        check("rst_per_din",   32'(bus_if.per_din),   32'd0);
`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
        check("rst_stat", 32'(stat_xfer_cnt), 32'd0);
`endif
        puc_rst_n = 1'b1;

        // Read at 0x0040 returning 0xA5C3
        bus_if.per_dout = 16'hA5C3;
        push(14'h0040, 16'h0000, 2'b00);
        check("rd_idle_en", 32'(bus_if.per_en), 32'd0);
        step(1);
        check("rd_en",      32'(bus_if.per_en),    32'd1);
        check("rd_addr",    32'(bus_if.per_addr),  32'h0040);
        check("rd_we",      32'(bus_if.per_we),    32'd0);
        check("rd_novalid", 32'(bus_if.rsp_valid), 32'd0);
        step(1);
        check("rd_en_off",  32'(bus_if.per_en),    32'd0);
        check("rd_addr_off",32'(bus_if.per_addr),  32'd0);
        check("rd_valid",   32'(bus_if.rsp_valid), 32'd1);
        check("rd_data",    32'(bus_if.rsp_data),  32'hA5C3);
        check("rd_wr",      32'(bus_if.rsp_wr),    32'd0);
        bus_if.per_dout = 16'h0000;
        step(1);
        check("rd_hold_valid", 32'(bus_if.rsp_valid), 32'd1);
        check("rd_hold_data",  32'(bus_if.rsp_data),  32'hA5C3);
        bus_if.rsp_ready = 1'b1;
        step(1);
        check("rd_done_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.rsp_ready = 1'b0;

        // Write 0x1234 to 0x0042, peripheral data must not leak into the response
        bus_if.per_dout = 16'hBEEF;
        push(14'h0042, 16'h1234, 2'b11);
        step(1);
        check("wr_en",   32'(bus_if.per_en),   32'd1);
        check("wr_addr", 32'(bus_if.per_addr), 32'h0042);
        check("wr_we",   32'(bus_if.per_we),   32'd3);
        check("wr_din",  32'(bus_if.per_din),  32'h1234);
        step(1);
        check("wr_valid", 32'(bus_if.rsp_valid), 32'd1);
        check("wr_data",  32'(bus_if.rsp_data),  32'h0000);
        check("wr_wr",    32'(bus_if.rsp_wr),    32'd1);
        bus_if.rsp_ready = 1'b1;
        step(1);
        check("wr_done_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.rsp_ready = 1'b0;

        // Backpressure: five writes, one in RESP and four stored
        en_addr_q.delete();
        en_din_q.delete();
        en_cyc_q.delete();
        for (int i = 0; i < 5; i++) begin
            push(14'h0100 + 14'(i), 16'hC000 + 16'(i), 2'b01);
        end
        check("bp_full_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("bp_valid",      32'(bus_if.rsp_valid), 32'd1);
        check("bp_wr",         32'(bus_if.rsp_wr),    32'd1);
        step(3);
        check("bp_one_access", 32'(en_addr_q.size()), 32'd1);
        check("bp_still_full", 32'(bus_if.cmd_ready), 32'd0);

        // Pop from full: cmd_ready stays low in the popping cycle, returns next cycle
        bus_if.rsp_ready = 1'b1;
        step(1);
        check("full_pop_en",    32'(bus_if.per_en),    32'd1);
        check("full_pop_addr",  32'(bus_if.per_addr),  32'h0101);
        check("full_pop_ready", 32'(bus_if.cmd_ready), 32'd0);
        step(1);
        check("full_next_ready", 32'(bus_if.cmd_ready), 32'd1);
        step(1);
        // Push during an ACCESS cycle (simultaneous push and pop)
        check("sim_in_access", 32'(bus_if.per_en), 32'd1);
        push(14'h0105, 16'hC005, 2'b01);
        for (int k = 0; k < 40 && en_addr_q.size() < 6; k++) begin
            step(1);
        end
        step(4);
        check("bp_count", 32'(en_addr_q.size()), 32'd6);
        for (int i = 0; i < en_addr_q.size(); i++) begin
            check($sformatf("order_addr%0d", i), 32'(en_addr_q[i]), 32'h0100 + 32'(i));
            check($sformatf("order_din%0d", i),  32'(en_din_q[i]),  32'hC000 + 32'(i));
        end
        for (int i = 2; i < en_cyc_q.size(); i++) begin
            check($sformatf("spacing%0d", i), 32'(en_cyc_q[i] - en_cyc_q[i-1]), 32'd2);
        end
        check("bp_idle_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("bp_idle_ready", 32'(bus_if.cmd_ready), 32'd1);
        bus_if.rsp_ready = 1'b0;

        // Reset while in RESP with three commands queued
        for (int i = 0; i < 4; i++) begin
            push(14'h0200 + 14'(i), 16'h0000, 2'b00);
        end
        check("mid_resp_valid", 32'(bus_if.rsp_valid), 32'd1);
        puc_rst_n = 1'b0;
        step(1);
        check("abort_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("abort_data",  32'(bus_if.rsp_data),  32'd0);
        check("abort_ready", 32'(bus_if.cmd_ready), 32'd1);
        check("abort_en",    32'(bus_if.per_en),    32'd0);
        puc_rst_n = 1'b1;
        n_before = en_addr_q.size();
        step(6);
        check("abort_no_access", 32'(en_addr_q.size()), 32'(n_before));
        check("abort_idle_valid", 32'(bus_if.rsp_valid), 32'd0);

`ifdef PERIPHERAL_NOC_MASTER_STATS_EN
        // 65537 accesses wrap the counter to 1
        check("stat_after_rst", 32'(stat_xfer_cnt), 32'd0);
        push_cnt = 0;
        bus_if.rsp_ready = 1'b1;
        bus_if.cmd_we    = 2'b01;
        bus_if.cmd_valid = 1'b1;
        for (int k = 0; k < 200000 && push_cnt < 65537; k++) begin
            step(1);
        end
        bus_if.cmd_valid = 1'b0;
        step(8);
        check("stat_pushes", 32'(push_cnt), 32'd65537);
        check("stat_wrap", 32'(stat_xfer_cnt), 32'h0001);
        bus_if.rsp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/peripheral_noc_master.md
PERIPHERAL_NOC_MASTER -- requirements
Module: peripheral_noc_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port mclk  input  1  main system clock; all logic on rising edge.
REQ-003 SHALL have port puc_rst_n  input  1  main system reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  host command valid.
REQ-005 SHALL have port cmd_ready  output  1  command FIFO can accept.
REQ-006 SHALL have port cmd_addr  input  14  target peripheral address.
REQ-007 SHALL have port cmd_data  input  16  write data.
REQ-008 SHALL have port cmd_we  input  2  byte write enables; 2'b00 = read.
REQ-009 SHALL have port rsp_valid  output  1  response valid.
REQ-010 SHALL have port rsp_ready  input  1  host accepts response.
REQ-011 SHALL have port rsp_data  output  16  read data; 0 for writes.
REQ-012 SHALL have port rsp_wr  output  1  response belongs to a write.
REQ-013 SHALL have port per_addr  output  14  peripheral address.
REQ-014 SHALL have port per_din  output  16  data to peripheral.
REQ-015 SHALL have port per_en  output  1  peripheral enable, active high.
REQ-016 SHALL have port per_we  output  2  peripheral write enable, active high.
REQ-017 SHALL have port per_dout  input  16  peripheral read data, valid in the per_en cycle.

Function
REQ-018 SHALL push {cmd_addr, cmd_data, cmd_we} on cycles with cmd_valid && cmd_ready; cmd_ready = FIFO not full (combinational from occupancy).
REQ-019 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; push when full impossible, pop when empty never occurs.
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 IDLE -> ACCESS when FIFO non-empty; else stay IDLE.
REQ-022 ACCESS lasts exactly one cycle: per_en=1, per_addr/per_din/per_we from FIFO head; head popped at end of cycle; -> RESP.
REQ-023 At end of ACCESS SHALL register rsp_data = per_dout if per_we==0 else 16'h0000, and rsp_wr = (per_we!=0).
REQ-024 RESP: rsp_valid=1 held with rsp_data/rsp_wr stable until rsp_ready; on handshake -> ACCESS if FIFO non-empty, else IDLE.
REQ-025 Outside ACCESS, per_en, per_we, per_addr, per_din SHALL be 0.
REQ-026 Push and pop in the same cycle SHALL leave occupancy unchanged; a pop from a full FIFO re-asserts cmd_ready the next cycle, not the same cycle.
REQ-027 Back-to-back throughput with rsp_ready held high SHALL be one access per 2 cycles; first per_en at earliest 1 cycle after push (IDLE cycle).
REQ-028 Commands SHALL issue to the peripheral bus strictly in acceptance order, one outstanding at a time.

Reset
REQ-029 puc_rst_n low at a clock edge SHALL set state IDLE, empty FIFO, and zero rsp_valid, rsp_data, rsp_wr, per_en, per_we, per_addr, per_din; cmd_ready=1 after reset.
REQ-030 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction, discard response and queued commands, with per_en=0 from the next cycle.

Configuration
REQ-031 With PERIPHERAL_NOC_MASTER_STATS_EN defined SHALL add port stat_xfer_cnt output 16, zero on reset, incremented on every ACCESS cycle, wrapping 16'hFFFF -> 16'h0000.
REQ-032 Without PERIPHERAL_NOC_MASTER_STATS_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Read: push addr 14'h0040, we 00, per_dout=16'hA5C3 -> one per_en cycle at addr 0040, rsp_valid with rsp_data A5C3, rsp_wr 0.
REQ-034 Write: push addr 14'h0042, data 16'h1234, we 11 -> per_en with per_we 11, per_din 1234; response rsp_data 0000, rsp_wr 1.
REQ-035 Backpressure: push 5 commands, rsp_ready low -> cmd_ready low after 4 stored plus 1 in RESP, per_en pulses once; release rsp_ready -> remaining 4 issued in order at 2-cycle spacing.
REQ-036 Full/simultaneous: FIFO full, pop occurs -> cmd_ready 1 next cycle; push+pop same cycle -> occupancy unchanged.
REQ-037 Reset mid-RESP with 3 queued -> rsp_valid 0, cmd_ready 1, no further per_en after reset.
REQ-038 STATS_EN: 65537 accesses -> stat_xfer_cnt = 16'h0001.
